// File: rtl/game_ctrl.sv
// game_ctrl: round controller for a timed game. It runs a pre-round
// countdown, a BCD round clock, a health counter with win/lose/pause
// handling, and a registered 4-digit display code word.
module game_ctrl #(
  parameter int START_MIN = 4,
  parameter int START_SEC = 44,
  parameter int WAIT_SEC  = 3,
  parameter int HP_W      = 3,
  parameter int HP_MAX    = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sec_tick,
  input  logic            enter,
  input  logic            pause,
  input  logic            hit,
  input  logic            heal,
  input  logic            goal,
  output logic [2:0]      state,
  output logic [3:0]      time_min,
  output logic [3:0]      time_s10,
  output logic [3:0]      time_s1,
  output logic [3:0]      wait_left,
  output logic [HP_W-1:0] hp,
  output logic            timeout,
  output logic [15:0]     seg_num
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_WAIT  = 3'd1,
    S_GAME  = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  localparam logic [3:0]      MIN0  = 4'(START_MIN);
  localparam logic [3:0]      S10_0 = 4'(START_SEC / 10);
  localparam logic [3:0]      S1_0  = 4'(START_SEC % 10);
  localparam logic [3:0]      WAIT0 = 4'(WAIT_SEC);
  localparam logic [HP_W-1:0] HP0   = HP_W'(HP_MAX);
  localparam logic [HP_W-1:0] HP1   = HP_W'(1);
  localparam logic [3:0]      DASH  = 4'hA;
  localparam logic [3:0]      BLANK = 4'hF;

  state_t state_reg;
  logic   blink_reg;

  // Decremented round clock, used whenever a second elapses in GAME.
  logic [3:0] dec_min, dec_s10, dec_s1;
  logic       expire;

  // Health step for the current cycle; hit and heal together cancel.
  logic            hp_dn, hp_up, lethal;
  logic [HP_W-1:0] hp_step;

  logic [15:0] time_disp;

  assign state     = state_reg;
  assign time_disp = {4'h0, time_min, time_s10, time_s1};

  // BCD borrow chain for one-second decrement plus expiry detect at 0:01.
  always_comb begin
    dec_min = time_min;
    dec_s10 = time_s10;
    dec_s1  = time_s1;
    if (time_s1 != 4'd0) begin
      dec_s1 = time_s1 - 4'd1;
    end else if (time_s10 != 4'd0) begin
      dec_s10 = time_s10 - 4'd1;
      dec_s1  = 4'd9;
    end else begin
      dec_min = time_min - 4'd1;
      dec_s10 = 4'd5;
      dec_s1  = 4'd9;
    end
    expire = sec_tick && (time_min == 4'd0) && (time_s10 == 4'd0) &&
             (time_s1 == 4'd1);
  end

  // Saturating health arithmetic and lethal-hit detect.
  always_comb begin
    hp_dn   = hit && !heal && (hp != '0);
    hp_up   = heal && !hit && (hp != HP0);
    lethal  = hit && !heal && (hp == HP1);
    hp_step = hp;
    if (hp_dn) begin
      hp_step = hp - HP1;
    end else if (hp_up) begin
      hp_step = hp + HP1;
    end
  end

  // Main round FSM with its counters; every output here is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_INIT;
      time_min  <= MIN0;
      time_s10  <= S10_0;
      time_s1   <= S1_0;
      wait_left <= WAIT0;
      hp        <= HP0;
      timeout   <= 1'b0;
      blink_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_INIT, S_WIN, S_LOSE: begin
          // A (re)start reloads everything as it enters WAIT.
          if (enter) begin
            state_reg <= S_WAIT;
            time_min  <= MIN0;
            time_s10  <= S10_0;
            time_s1   <= S1_0;
            wait_left <= WAIT0;
            hp        <= HP0;
            timeout   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (sec_tick) begin
            wait_left <= wait_left - 4'd1;
            if (wait_left == 4'd1) begin
              state_reg <= S_GAME;
            end
          end
        end
        S_GAME: begin
          if (goal) begin
            // Winning beats any simultaneous loss; the clock still runs
            // for this second but health is left as it was.
            state_reg <= S_WIN;
            timeout   <= 1'b0;
            if (sec_tick) begin
              time_min <= dec_min;
              time_s10 <= dec_s10;
              time_s1  <= dec_s1;
            end
          end else begin
            if (sec_tick) begin
              time_min <= dec_min;
              time_s10 <= dec_s10;
              time_s1  <= dec_s1;
            end
            hp <= hp_step;
            if (expire) begin
              // Expiry is reported as a timeout even if a lethal hit coincides.
              state_reg <= S_LOSE;
              timeout   <= 1'b1;
            end else if (lethal) begin
              state_reg <= S_LOSE;
              timeout   <= 1'b0;
            end else if (pause) begin
              state_reg <= S_PAUSE;
              blink_reg <= 1'b0;
            end
          end
        end
        S_PAUSE: begin
          if (pause) begin
            state_reg <= S_GAME;
          end else if (sec_tick) begin
            blink_reg <= !blink_reg;
          end
        end
        default: begin
          state_reg <= S_INIT;
        end
      endcase
    end
  end

  // Display word built from this cycle's registers, so it lags by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_num <= {DASH, DASH, DASH, DASH};
    end else begin
      case (state_reg)
        S_WAIT:         seg_num <= {DASH, DASH, DASH, wait_left};
        S_GAME, S_WIN:  seg_num <= time_disp;
        S_PAUSE:        seg_num <= blink_reg ? {BLANK, BLANK, BLANK, BLANK}
                                             : time_disp;
        default:        seg_num <= {DASH, DASH, DASH, DASH};
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed scenarios plus random stimulus for game_ctrl,
// checked every cycle against a seconds-based behavioural model.
module tb_game_ctrl;

  localparam int HP_W   = 3;
  localparam int HP_MAX = 7;
  localparam int T0     = 4 * 60 + 44;
  localparam int W0     = 3;

  logic clk = 1'b0;
  logic rst, sec_tick, enter, pause, hit, heal, goal;
  logic [2:0]      state;
  logic [3:0]      time_min, time_s10, time_s1, wait_left;
  logic [HP_W-1:0] hp;
  logic            timeout;
  logic [15:0]     seg_num;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: state as 0..5, remaining time in plain seconds.
  int m_state, m_time, m_wait, m_hp, m_to, m_phase;
  logic [15:0] m_seg;

  game_ctrl #(.START_MIN(4), .START_SEC(44), .WAIT_SEC(3), .HP_W(HP_W),
              .HP_MAX(HP_MAX)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .enter(enter), .pause(pause),
    .hit(hit), .heal(heal), .goal(goal), .state(state), .time_min(time_min),
    .time_s10(time_s10), .time_s1(time_s1), .wait_left(wait_left), .hp(hp),
    .timeout(timeout), .seg_num(seg_num)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] show_time(int t);
    return {4'h0, 4'(t / 60), 4'((t % 60) / 10), 4'(t % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_time = T0; m_wait = W0; m_hp = HP_MAX; m_to = 0;
    m_phase = 0; m_seg = 16'hAAAA;
  endtask

  task automatic model_load();
    m_state = 1; m_time = T0; m_wait = W0; m_hp = HP_MAX; m_to = 0;
  endtask

  // One clock of the rules, applied at the rising edge.
  task automatic model_step();
    int nt, nh;
    if (rst) begin
      model_reset();
      return;
    end
    case (m_state)
      1:       m_seg = {12'hAAA, 4'(m_wait)};
      2, 3:    m_seg = show_time(m_time);
      5:       m_seg = m_phase ? 16'hFFFF : show_time(m_time);
      default: m_seg = 16'hAAAA;
    endcase
    case (m_state)
      0, 3, 4: if (enter) model_load();
      1: if (sec_tick) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) m_state = 2;
      end
      2: begin
        nt = sec_tick ? m_time - 1 : m_time;
        nh = m_hp;
        if (hit && !heal && nh > 0) nh = nh - 1;
        else if (heal && !hit && nh < HP_MAX) nh = nh + 1;
        if (goal) begin
          m_time = nt; m_state = 3; m_to = 0;
        end else begin
          m_time = nt; m_hp = nh;
          if (sec_tick && nt == 0) begin
            m_state = 4; m_to = 1;
          end else if (nh == 0) begin
            m_state = 4; m_to = 0;
          end else if (pause) begin
            m_state = 5; m_phase = 0;
          end
        end
      end
      5: if (pause) m_state = 2;
         else if (sec_tick) m_phase = 1 - m_phase;
      default: m_state = 0;
    endcase
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (state !== 3'(m_state) || {time_min, time_s10, time_s1} !== show_time(m_time) ||
          wait_left !== 4'(m_wait) || hp !== HP_W'(m_hp) || timeout !== 1'(m_to) ||
          seg_num !== m_seg) begin
        errors++;
        $display("FAIL cycle_model t=%0t: got st=%0d time=%h wait=%0d hp=%0d to=%0d seg=%h, need st=%0d time=%h wait=%0d hp=%0d to=%0d seg=%h",
                 $time, state, {time_min, time_s10, time_s1}, wait_left, hp, timeout, seg_num,
                 m_state, show_time(m_time), m_wait, m_hp, m_to, m_seg);
      end
    end
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, need %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic check_time(string name, int mn, int s10, int s1);
    check(name, {time_min, time_s10, time_s1}, (mn << 8) | (s10 << 4) | s1);
  endtask

  // Drive one clock with the given pulses; returns just after the falling edge.
  task automatic cyc(bit en, bit pa, bit hi, bit he, bit go, bit tk);
    enter = en; pause = pa; hit = hi; heal = he; goal = go; sec_tick = tk;
    @(posedge clk);
    model_step();
    @(negedge clk);
    enter = 0; pause = 0; hit = 0; heal = 0; goal = 0; sec_tick = 0;
  endtask

  task automatic ticks(int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 1);
  endtask

  task automatic start_round();
    cyc(1, 0, 0, 0, 0, 0);
    ticks(3);
  endtask

  initial begin
    rst = 1; sec_tick = 0; enter = 0; pause = 0; hit = 0; heal = 0; goal = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_state", state, 0);
    check("reset_seg", seg_num, 16'hAAAA);
    check_time("reset_time", 4, 4, 4);
    check("reset_hp", hp, 7);
    rst = 0;

    // Start sequence
    cyc(1, 0, 0, 0, 0, 0);
    check("wait_entry_state", state, 1);
    check("wait_entry_left", wait_left, 3);
    cyc(0, 0, 0, 0, 0, 0);
    check("wait_seg", seg_num, 16'hAAA3);
    ticks(1); check("wait_left2", wait_left, 2);
    ticks(1); check("wait_left1", wait_left, 1);
    ticks(1); check("game_entry", state, 2);
    check_time("game_time", 4, 4, 4);
    check("game_hp", hp, 7);

    // Clock borrow boundaries and timeout
    ticks(224); check_time("at_1_00", 1, 0, 0);
    ticks(1);   check_time("at_0_59", 0, 5, 9);
    ticks(49);  check_time("at_0_10", 0, 1, 0);
    ticks(1);   check_time("at_0_09", 0, 0, 9);
    ticks(8);   check_time("at_0_01", 0, 0, 1);
    ticks(1);
    check("expire_state", state, 4);
    check("expire_timeout", timeout, 1);
    check_time("expire_time", 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("lose_seg", seg_num, 16'hAAAA);

    // Restart from LOSE
    cyc(1, 0, 0, 0, 0, 0);
    check("restart_state", state, 1);
    check_time("restart_time", 4, 4, 4);
    check("restart_hp", hp, 7);
    check("restart_timeout", timeout, 0);
    ticks(3);

    // Health saturation and cancel
    cyc(0, 0, 0, 1, 0, 0); check("heal_sat", hp, 7);
    cyc(0, 0, 1, 1, 0, 0); check("hit_heal", hp, 7);
    cyc(0, 0, 1, 0, 0, 0); check("hit_one", hp, 6);
    repeat (5) cyc(0, 0, 1, 0, 0, 0);
    check("hp_one", hp, 1);
    cyc(0, 0, 1, 0, 1, 0);
    check("goal_pri_state", state, 3);
    check("goal_pri_hp", hp, 1);
    check("goal_pri_to", timeout, 0);
    start_round();
    repeat (6) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    check("lethal_state", state, 4);
    check("lethal_hp", hp, 0);
    check("lethal_to", timeout, 0);

    // Pause freeze and blink
    start_round();
    ticks(134); check_time("at_2_30", 2, 3, 0);
    cyc(0, 1, 0, 0, 0, 0); check("pause_state", state, 5);
    ticks(1); check("blink_show", seg_num, 16'h0230);
    ticks(1); check("blink_blank", seg_num, 16'hFFFF);
    ticks(3);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("unpause_state", state, 2);
    check_time("unpause_time", 2, 3, 0);
    check("unpause_hp", hp, 7);

    // Asynchronous reset mid-round
    #2 rst = 1;
    #1 check("async_rst_state", state, 0);
    check("async_rst_seg", seg_num, 16'hAAAA);
    model_reset();
    @(negedge clk);
    rst = 0;

    // Random stimulus
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 59) == 0, $urandom_range(0, 1) == 0);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter START_MIN, default 4, BCD minutes loaded at round start, legal range 0-9.
REQ-002 Parameter START_SEC, default 44, seconds loaded at round start, legal range 0-59; START_MIN:START_SEC SHALL be nonzero.
REQ-003 Parameter WAIT_SEC, default 3, pre-round countdown length in seconds, legal range 1-9.
REQ-004 Parameter HP_W, default 3, width of the health counter.
REQ-005 Parameter HP_MAX, default 7, health at round start, legal range 1 to 2^HP_W-1.
REQ-006 clk  input  1  system clock; all registers on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 sec_tick  input  1  one-cycle strobe, once per second.
REQ-009 enter  input  1  one-cycle pulse, start/restart request.
REQ-010 pause  input  1  one-cycle pulse, pause toggle.
REQ-011 hit  input  1  one-cycle pulse, lose one HP.
REQ-012 heal  input  1  one-cycle pulse, gain one HP.
REQ-013 goal  input  1  one-cycle pulse, win condition reached.
REQ-014 state  output  3  INIT=0, WAIT=1, GAME=2, WIN=3, LOSE=4, PAUSE=5.
REQ-015 time_min, time_s10, time_s1  output  4 each  BCD remaining time.
REQ-016 wait_left  output  4  remaining pre-round seconds.
REQ-017 hp  output  HP_W  current health.
REQ-018 timeout  output  1  high in LOSE when the loss was caused by time expiry.
REQ-019 seg_num  output  16  four 4-bit display codes, code 10 = dash, code 15 = blank.

Function
REQ-020 INIT: enter -> WAIT; all other inputs ignored.
REQ-021 Every transition into WAIT SHALL load wait_left=WAIT_SEC, time=START_MIN:START_SEC (BCD), hp=HP_MAX, timeout=0, in the same cycle as the transition.
REQ-022 WAIT: sec_tick decrements wait_left; sec_tick with wait_left==1 -> wait_left=0 and state GAME in the same cycle.
REQ-023 GAME: sec_tick decrements time: s1>0 -> s1-1; s1==0 -> s1=9 with s10-1; s10==0 and s1==0 -> s10=5, s1=9, min-1.
REQ-024 GAME: sec_tick with time==0:01 -> time=0:00, state LOSE, timeout=1, same cycle.
REQ-025 GAME: hit decrements hp, floor 0; hit with hp==1 -> hp=0, state LOSE, timeout=0.
REQ-026 GAME: heal increments hp, saturating at HP_MAX; hit and heal in the same cycle -> hp unchanged.
REQ-027 GAME: goal -> WIN; goal has priority over simultaneous lethal hit or time expiry (state WIN, timeout=0); the time decrement still applies, and the HP update does not.
REQ-028 GAME: pause (no goal, no loss that cycle) -> PAUSE; loss or goal has priority over pause.
REQ-029 PAUSE: time and hp frozen; sec_tick, hit, heal, goal, enter ignored; pause -> GAME.
REQ-030 WIN and LOSE: time, hp, timeout held; enter -> WAIT per REQ-021; other inputs ignored.
REQ-031 seg_num SHALL be registered, reflecting state/counters of the previous cycle (1-cycle latency).
REQ-032 seg_num map: INIT/LOSE -> {10,10,10,10}; WAIT -> {10,10,10,wait_left}; GAME/WIN -> {0,min,s10,s1}.
REQ-033 PAUSE: seg_num alternates each sec_tick between {0,min,s10,s1} and {15,15,15,15}, starting with the time shown; the phase is reset on entry to PAUSE.
REQ-034 Unused state encodings 6-7 SHALL recover to INIT on the next clock.

Reset
REQ-035 rst SHALL immediately force state=INIT, time=START_MIN:START_SEC, wait_left=WAIT_SEC, hp=HP_MAX, timeout=0, seg_num={10,10,10,10}, blink phase=0.
REQ-036 rst asserted mid-round (any state) SHALL abandon the round; no counter value survives reset.

Verification
REQ-037 Reset, enter, 3 sec_tick -> WAIT with wait_left 3,2,1, then GAME with time 4:44, hp=7; seg_num {10,10,10,3} one cycle after WAIT entry.
REQ-038 GAME at 1:00, one sec_tick -> 0:59; at 0:10 -> 0:09; at 0:01 -> 0:00, LOSE, timeout=1, seg_num {10,10,10,10}.
REQ-039 GAME hp=1, hit and goal in the same cycle -> WIN, hp=1, timeout=0; separately hp=1, hit only -> LOSE, hp=0.
REQ-040 GAME hp=7: heal -> 7; hit+heal -> 7; hit -> 6.
REQ-041 GAME 2:30, pause, 5 sec_tick, hit, pause -> GAME, time 2:30, hp unchanged; seg_num blinks time/blank across the ticks.
REQ-042 LOSE, enter -> WAIT with time 4:44, hp=7, timeout=0; rst during GAME -> INIT asynchronously, before the next clock edge.
